ysyx_22040237_idu_stage: RTL and testbench

Pipelined, parametrised decode stage sitting between the IFU and the EXU. Accepts one fetched instruction per cycle over a valid/ready handshake and decodes the RV64I subset: addi, add, sub, lui, auipc, jal, jalr and ebreak. Samples register-file read data and delivers a registered decode bundle (ALU opcode, operands, register-file controls, jump info) to the EXU over a second valid/ready handshake, with flush support.

---
 rtl/ysyx_22040237_idu_stage_if.sv | 40 ++++
 rtl/ysyx_22040237_idu_stage.sv | 142 ++++++++++++++
 tb/tb_ysyx_22040237_idu_stage.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22040237_idu_stage_if.sv
// Handshake and data bundle between the IFU/regfile/EXU environment and the decode stage.
// The stage uses the slave modport and the environment drives the master modport.
interface ysyx_22040237_idu_stage_if #(
  parameter int XLEN  = 64,
  parameter int PC_W  = 32,
  parameter int OPC_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [PC_W-1:0]  in_pc;
  logic [31:0]      in_inst;
  logic [4:0]       rs1_addr;
  logic [4:0]       rs2_addr;
  logic [XLEN-1:0]  rs1_data;
  logic [XLEN-1:0]  rs2_data;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [OPC_W-1:0] out_alu_op;
  logic [XLEN-1:0]  out_op1;
  logic [XLEN-1:0]  out_op2;
  logic             out_rd_w_en;
  logic [4:0]       out_rd_w_addr;
  logic             out_jmp;
  logic [PC_W-1:0]  out_jmp_target;
  logic             out_ebreak;
  logic             out_illegal;

  modport slave (
    input  in_valid, in_pc, in_inst, rs1_data, rs2_data, flush, out_ready,
    output in_ready, rs1_addr, rs2_addr, out_valid, out_alu_op, out_op1, out_op2,
           out_rd_w_en, out_rd_w_addr, out_jmp, out_jmp_target, out_ebreak, out_illegal
  );

  modport master (
    output in_valid, in_pc, in_inst, rs1_data, rs2_data, flush, out_ready,
    input  in_ready, rs1_addr, rs2_addr, out_valid, out_alu_op, out_op1, out_op2,
           out_rd_w_en, out_rd_w_addr, out_jmp, out_jmp_target, out_ebreak, out_illegal
  );
endinterface

// File: rtl/ysyx_22040237_idu_stage.sv
// RV64I-subset decode stage: one registered decode bundle between IFU and EXU, with flush.
// Define YSYX_22040237_IDU_PERF_EN to add the saturating perf_stall_cnt output.
module ysyx_22040237_idu_stage #(
  parameter int XLEN  = 64,
  parameter int PC_W  = 32,
  parameter int OPC_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  ysyx_22040237_idu_stage_if.slave bus
`ifdef YSYX_22040237_IDU_PERF_EN
  , output logic [31:0] perf_stall_cnt
`endif
);

  localparam logic [OPC_W-1:0] OP_ADD = OPC_W'(8'h11);
  localparam logic [OPC_W-1:0] OP_SUB = OPC_W'(8'h12);

  typedef struct packed {
    logic [OPC_W-1:0] alu_op;
    logic [XLEN-1:0]  op1;
    logic [XLEN-1:0]  op2;
    logic             rd_w_en;
    logic [4:0]       rd_w_addr;
    logic             jmp;
    logic [PC_W-1:0]  jmp_target;
    logic             ebreak;
    logic             illegal;
  } bundle_t;

  bundle_t dec_d, out_q;
  logic    valid_q;
  logic    accept;
  logic    writes_rd;

  logic [31:0]     inst;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      rd;
  logic [XLEN-1:0] imm_i, imm_u, pc_x;
  logic [PC_W-1:0] imm_j, jalr_sum;

  assign inst     = bus.in_inst;
  assign opcode   = inst[6:0];
  assign rd       = inst[11:7];
  assign funct3   = inst[14:12];
  assign funct7   = inst[31:25];
  assign imm_i    = {{(XLEN-12){inst[31]}}, inst[31:20]};
  assign imm_u    = {{(XLEN-32){inst[31]}}, inst[31:12], 12'h000};
  assign imm_j    = {{(PC_W-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign pc_x     = {{(XLEN-PC_W){1'b0}}, bus.in_pc};
  // Only the low PC_W bits of rs1+imm reach the target, so the sum is done at PC width.
  assign jalr_sum = bus.rs1_data[PC_W-1:0] + imm_i[PC_W-1:0];

  assign bus.rs1_addr = inst[19:15];
  assign bus.rs2_addr = inst[24:20];

  // NOTE: every field gets a default before the case so no path can infer a latch.
  always_comb begin
    dec_d     = '0;
    writes_rd = 1'b0;
    unique case (opcode)
      7'b0010011: begin
        if (funct3 == 3'b000) begin
          dec_d.alu_op = OP_ADD; dec_d.op1 = bus.rs1_data; dec_d.op2 = imm_i; writes_rd = 1'b1;
        end else dec_d.illegal = 1'b1;
      end
      7'b0110011: begin
        if (funct3 == 3'b000 && funct7 == 7'b0000000) begin
          dec_d.alu_op = OP_ADD; dec_d.op1 = bus.rs1_data; dec_d.op2 = bus.rs2_data; writes_rd = 1'b1;
        end else if (funct3 == 3'b000 && funct7 == 7'b0100000) begin
          dec_d.alu_op = OP_SUB; dec_d.op1 = bus.rs1_data; dec_d.op2 = bus.rs2_data; writes_rd = 1'b1;
        end else dec_d.illegal = 1'b1;
      end
      7'b0110111: begin
        dec_d.alu_op = OP_ADD; dec_d.op2 = imm_u; writes_rd = 1'b1;
      end
      7'b0010111: begin
        dec_d.alu_op = OP_ADD; dec_d.op1 = pc_x; dec_d.op2 = imm_u; writes_rd = 1'b1;
      end
      7'b1101111: begin
        dec_d.alu_op = OP_ADD; dec_d.op1 = pc_x; dec_d.op2 = XLEN'(4); writes_rd = 1'b1;
        dec_d.jmp = 1'b1; dec_d.jmp_target = bus.in_pc + imm_j;
      end
      7'b1100111: begin
        if (funct3 == 3'b000) begin
          dec_d.alu_op = OP_ADD; dec_d.op1 = pc_x; dec_d.op2 = XLEN'(4); writes_rd = 1'b1;
          dec_d.jmp = 1'b1; dec_d.jmp_target = jalr_sum & ~PC_W'(1);
        end else dec_d.illegal = 1'b1;
      end
      7'b1110011: begin
        if (inst == 32'h0010_0073) dec_d.ebreak = 1'b1;
        else dec_d.illegal = 1'b1;
      end
      default: dec_d.illegal = 1'b1;
    endcase
    dec_d.rd_w_en   = writes_rd && (rd != 5'd0);
    dec_d.rd_w_addr = dec_d.rd_w_en ? rd : 5'd0;
  end

  assign bus.in_ready = !valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      out_q   <= '0;
    end else if (bus.flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      out_q   <= dec_d;
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.out_valid      = valid_q;
  assign bus.out_alu_op     = out_q.alu_op;
  assign bus.out_op1        = out_q.op1;
  assign bus.out_op2        = out_q.op2;
  assign bus.out_rd_w_en    = out_q.rd_w_en;
  assign bus.out_rd_w_addr  = out_q.rd_w_addr;
  assign bus.out_jmp        = out_q.jmp;
  assign bus.out_jmp_target = out_q.jmp_target;
  assign bus.out_ebreak     = out_q.ebreak;
  assign bus.out_illegal    = out_q.illegal;

`ifdef YSYX_22040237_IDU_PERF_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_q <= '0;
    else if (valid_q && !bus.out_ready && stall_q != 32'hFFFF_FFFF) stall_q <= stall_q + 32'd1;
  end

  assign perf_stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_ysyx_22040237_idu_stage.sv
// Directed plus randomized bench for the decode stage against a spec-level reference model.
// Define YSYX_22040237_IDU_PERF_EN to also check the stall counter.
module tb_ysyx_22040237_idu_stage;
  localparam int XLEN = 64, PC_W = 32, OPC_W = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ysyx_22040237_idu_stage_if #(.XLEN(XLEN), .PC_W(PC_W), .OPC_W(OPC_W)) bus ();

`ifdef YSYX_22040237_IDU_PERF_EN
  logic [31:0] perf_stall_cnt;
`endif

  ysyx_22040237_idu_stage #(.XLEN(XLEN), .PC_W(PC_W), .OPC_W(OPC_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
`ifdef YSYX_22040237_IDU_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  typedef struct packed {
    logic [7:0]  alu_op;
    logic [63:0] op1;
    logic [63:0] op2;
    logic        rd_w_en;
    logic [4:0]  rd_w_addr;
    logic        jmp;
    logic [31:0] jmp_target;
    logic        ebreak;
    logic        illegal;
  } bundle_t;

  int n_cmp = 0;
  int n_err = 0;

  bit          m_valid;
  bundle_t     m_out;
  logic [31:0] m_stall;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bundle_t observed();
    bundle_t b;
    b.alu_op     = bus.out_alu_op;
    b.op1        = bus.out_op1;
    b.op2        = bus.out_op2;
    b.rd_w_en    = bus.out_rd_w_en;
    b.rd_w_addr  = bus.out_rd_w_addr;
    b.jmp        = bus.out_jmp;
    b.jmp_target = bus.out_jmp_target;
    b.ebreak     = bus.out_ebreak;
    b.illegal    = bus.out_illegal;
    return b;
  endfunction

  // Reference decode written directly from the instruction-set rules using integer arithmetic.
  function automatic bundle_t ref_decode(input logic [31:0] inst, input logic [31:0] pc,
                                         input logic [63:0] r1, input logic [63:0] r2);
    bundle_t     b;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    longint      imm_i, imm_u, imm_j;
    logic [63:0] pcx, t;
    bit          writes;
    b      = '0;
    writes = 0;
    opc    = inst[6:0];
    f3     = inst[14:12];
    f7     = inst[31:25];
    rd     = inst[11:7];
    imm_i  = longint'($signed(inst[31:20]));
    imm_u  = longint'($signed({inst[31:12], 12'h000}));
    imm_j  = longint'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
    pcx    = 64'(pc);
    if (inst == 32'h0010_0073) b.ebreak = 1;
    else if (opc == 7'h13 && f3 == 0) begin
      b.alu_op = 8'h11; b.op1 = r1; b.op2 = imm_i; writes = 1;
    end else if (opc == 7'h33 && f3 == 0 && f7 == 7'h00) begin
      b.alu_op = 8'h11; b.op1 = r1; b.op2 = r2; writes = 1;
    end else if (opc == 7'h33 && f3 == 0 && f7 == 7'h20) begin
      b.alu_op = 8'h12; b.op1 = r1; b.op2 = r2; writes = 1;
    end else if (opc == 7'h37) begin
      b.alu_op = 8'h11; b.op1 = 0; b.op2 = imm_u; writes = 1;
    end else if (opc == 7'h17) begin
      b.alu_op = 8'h11; b.op1 = pcx; b.op2 = imm_u; writes = 1;
    end else if (opc == 7'h6F) begin
      b.alu_op = 8'h11; b.op1 = pcx; b.op2 = 4; writes = 1; b.jmp = 1;
      t = pcx + imm_j; b.jmp_target = t[31:0];
    end else if (opc == 7'h67 && f3 == 0) begin
      b.alu_op = 8'h11; b.op1 = pcx; b.op2 = 4; writes = 1; b.jmp = 1;
      t = r1 + imm_i; b.jmp_target = t[31:0] & 32'hFFFF_FFFE;
    end else b.illegal = 1;
    if (writes && rd != 0) begin
      b.rd_w_en = 1; b.rd_w_addr = rd;
    end
    return b;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    int          k;
    r = $urandom;
    k = $urandom_range(0, 9);
    case (k)
      0: return {r[31:15], 3'b000, r[11:7], 7'h13};
      1: return {1'b0, r[30], 5'b00000, r[24:15], 3'b000, r[11:7], 7'h33};
      2: return {r[31:7], 7'h37};
      3: return {r[31:7], 7'h17};
      4: return {r[31:7], 7'h6F};
      5: return {r[31:15], 3'b000, r[11:7], 7'h67};
      6: return 32'h0010_0073;
      7: return {r[31:7], 7'h73};
      default: return r;
    endcase
  endfunction

  task automatic drive(input logic iv, input logic [31:0] inst, input logic [31:0] pc,
                       input logic [63:0] r1, input logic [63:0] r2,
                       input logic ordy, input logic fl);
    bus.in_valid  = iv;
    bus.in_inst   = inst;
    bus.in_pc     = pc;
    bus.rs1_data  = r1;
    bus.rs2_data  = r2;
    bus.out_ready = ordy;
    bus.flush     = fl;
  endtask

  // Checks combinational outputs, advances one clock, updates the model and checks the bundle.
  task automatic cycle(input string tag);
    bit      acc, stall;
    bundle_t d;
    logic [31:0] inst_v;
    #1;
    inst_v = bus.in_inst;
    check({tag, ":in_ready"}, 256'(bus.in_ready), 256'(!m_valid || bus.out_ready));
    check({tag, ":rs_addr"}, 256'({bus.rs1_addr, bus.rs2_addr}), 256'({inst_v[19:15], inst_v[24:20]}));
    acc   = bus.in_valid && (!m_valid || bus.out_ready) && !bus.flush;
    stall = m_valid && !bus.out_ready;
    d     = ref_decode(bus.in_inst, bus.in_pc, bus.rs1_data, bus.rs2_data);
    @(posedge clk);
    #1;
    if (bus.flush) m_valid = 0;
    else if (acc) begin
      m_valid = 1;
      m_out   = d;
    end else if (bus.out_ready) m_valid = 0;
    if (stall && m_stall != 32'hFFFF_FFFF) m_stall++;
    check({tag, ":out_valid"}, 256'(bus.out_valid), 256'(m_valid));
    if (m_valid) check({tag, ":bundle"}, 256'(observed()), 256'(m_out));
`ifdef YSYX_22040237_IDU_PERF_EN
    check({tag, ":stall_cnt"}, 256'(perf_stall_cnt), 256'(m_stall));
`endif
  endtask

  task automatic model_reset();
    m_valid = 0;
    m_out   = '0;
    m_stall = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 32'h0, 32'h0, 64'h0, 64'h0, 1, 0);
    model_reset();
    #3;
    check("reset:out_valid", 256'(bus.out_valid), 256'(0));
    check("reset:bundle", 256'(observed()), 256'(0));
    check("reset:in_ready", 256'(bus.in_ready), 256'(1));
    @(posedge clk);
    #1 rst_n = 1'b1;

    drive(1, 32'hFFF1_0093, 32'h8000_0000, 64'd5, 64'd0, 1, 0);
    cycle("addi");
    check("addi:fields", 256'({observed().alu_op, observed().op1, observed().op2, observed().rd_w_addr}),
          256'({8'h11, 64'd5, 64'hFFFF_FFFF_FFFF_FFFF, 5'd1}));

    drive(1, 32'h8000_0297, 32'h8000_0000, 64'd0, 64'd0, 1, 0);
    cycle("auipc");
    check("auipc:ops", 256'({observed().op1, observed().op2, observed().rd_w_addr}),
          256'({64'h8000_0000, 64'hFFFF_FFFF_8000_0000, 5'd5}));

    drive(1, 32'h1234_5037, 32'h8000_0004, 64'd0, 64'd0, 1, 0);
    cycle("lui_x0");
    check("lui_x0:rd_w_en", 256'(bus.out_rd_w_en), 256'(0));

    drive(1, 32'h0081_80E7, 32'h8000_0100, 64'h8000_0013, 64'd0, 1, 0);
    cycle("jalr");
    check("jalr:jump", 256'({bus.out_jmp, bus.out_jmp_target, bus.out_op1, bus.out_op2}),
          256'({1'b1, 32'h8000_001A, 64'h8000_0100, 64'd4}));

    drive(1, 32'h0020_81B3, 32'h8000_0108, 64'd10, 64'd20, 1, 0);
    cycle("add");
    drive(1, 32'h4020_8233, 32'h8000_010C, 64'd10, 64'd3, 0, 0);
    repeat (3) cycle("backpressure");
`ifdef YSYX_22040237_IDU_PERF_EN
    check("backpressure:stall3", 256'(perf_stall_cnt), 256'(3));
`endif
    drive(1, 32'h4020_8233, 32'h8000_010C, 64'd10, 64'd3, 1, 0);
    cycle("bp_release");
    check("bp_release:sub", 256'({bus.out_alu_op, bus.out_rd_w_addr}), 256'({8'h12, 5'd4}));

    drive(1, 32'hFFF1_0093, 32'h8000_0110, 64'd7, 64'd0, 0, 1);
    cycle("flush");
    check("flush:dropped", 256'(bus.out_valid), 256'(0));

    drive(1, 32'hFFFF_FFFF, 32'h8000_0114, 64'd1, 64'd2, 1, 0);
    cycle("illegal");
    check("illegal:flags", 256'({bus.out_illegal, bus.out_rd_w_en, bus.out_alu_op}), 256'({1'b1, 1'b0, 8'h00}));

    drive(1, 32'h0010_0073, 32'h8000_0118, 64'd1, 64'd2, 1, 0);
    cycle("ebreak");
    check("ebreak:flags", 256'({bus.out_ebreak, bus.out_rd_w_en}), 256'({1'b1, 1'b0}));

    drive(1, 32'h0100_00EF, 32'h0000_0100, 64'd0, 64'd0, 1, 0);
    cycle("jal");
    check("jal:target", 256'(bus.out_jmp_target), 256'(32'h0000_0110));

    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 3) != 0), rand_inst(), $urandom, {$urandom, $urandom},
            {$urandom, $urandom}, ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0));
      cycle("random");
    end

    drive(1, 32'hFFF1_0093, 32'h8000_0200, 64'd9, 64'd0, 0, 0);
    cycle("pre_async_reset");
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("async_reset:out_valid", 256'(bus.out_valid), 256'(0));
    check("async_reset:bundle", 256'(observed()), 256'(0));
`ifdef YSYX_22040237_IDU_PERF_EN
    check("async_reset:stall_cnt", 256'(perf_stall_cnt), 256'(0));
`endif
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(1, 32'h0020_81B3, 32'h8000_0204, 64'd1, 64'd1, 1, 0);
    cycle("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
